// File: rtl/regwb_pkg.sv
// Shared types and default widths for the register write-back queue.
package regwb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer holding write-back entries; exposes the head, the
// raw storage and an occupancy mask so the top level can search queued entries.
module wb_fifo
  import regwb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t,
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_push,
  input  entry_t         i_entry,
  input  logic           i_pop,
  output entry_t         o_head,
  output entry_t         o_entries [DEPTH],
  output logic [PW-1:0]  o_head_ptr,
  output logic [DEPTH-1:0] o_mask,
  output logic [PW:0]    o_count
);

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  entry_t        r_mem [DEPTH];

  logic          w_do_push;
  logic          w_do_pop;
  logic [PW-1:0] w_off [DEPTH];

  assign w_do_push = i_push && (r_count != (PW+1)'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (w_do_push) r_tail <= r_tail + 1'b1;
      if (w_do_pop)  r_head <= r_head + 1'b1;
      r_count <= r_count + (PW+1)'(w_do_push) - (PW+1)'(w_do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; the cleared count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_tail] <= i_entry;
  end

  // Entry i is occupied when its distance from the head (mod DEPTH) is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
    assign w_off[gi]  = PW'(gi) - r_head;
    assign o_mask[gi] = ({1'b0, w_off[gi]} < r_count);
  end

  assign o_head     = r_mem[r_head];
  assign o_entries  = r_mem;
  assign o_head_ptr = r_head;
  assign o_count    = r_count;

endmodule

// File: rtl/reg_writeback_queue.sv
// Write-back queue with x0 filtering, register-file drain port and operand
// forwarding. Forwarding comparators are built only when WB_BYPASS_EN is defined.
module reg_writeback_queue #(
  parameter int  DEPTH = 4,
  parameter int  XLEN  = regwb_pkg::XLEN,
  parameter int  AW    = regwb_pkg::REG_ADDR_W,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rd,
  input  logic [XLEN-1:0] in_data,
  input  logic            rf_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd1_value,
  output logic [XLEN-1:0] fwd2_value,
  output logic [PW:0]     pending
);

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } q_entry_t;

  q_entry_t         w_in_entry;
  q_entry_t         w_head;
  q_entry_t         w_entries [DEPTH];
  logic [PW-1:0]    w_head_ptr;
  logic [DEPTH-1:0] w_mask;
  logic             w_push;
  logic             w_pop;

  assign in_ready = (pending < (PW+1)'(DEPTH));
  assign rf_we    = (pending != '0);

  // x0 results complete the handshake but never occupy a slot.
  assign w_push     = in_valid && in_ready && (in_rd != '0);
  assign w_pop      = rf_we && rf_ready;
  assign w_in_entry = '{rd: in_rd, data: in_data};

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (q_entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_entry    (w_in_entry),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_entries  (w_entries),
    .o_head_ptr (w_head_ptr),
    .o_mask     (w_mask),
    .o_count    (pending)
  );

  assign rf_waddr = rf_we ? w_head.rd   : '0;
  assign rf_wdata = rf_we ? w_head.data : '0;

`ifdef WB_BYPASS_EN
  // Walk entries oldest to youngest so the last match is the newest value.
  function automatic logic [XLEN:0] fwd_lookup(input logic [AW-1:0] rs);
    logic [PW-1:0] idx;
    logic [XLEN:0] res;
    res = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = w_head_ptr + PW'(k);
      if ((rs != '0) && w_mask[idx] && (w_entries[idx].rd == rs))
        res = {1'b1, w_entries[idx].data};
    end
    return res;
  endfunction

  always_comb begin
    {fwd1_hit, fwd1_value} = fwd_lookup(rs1);
    {fwd2_hit, fwd2_value} = fwd_lookup(rs2);
  end
`else
  logic w_unused;

  assign fwd1_hit   = 1'b0;
  assign fwd2_hit   = 1'b0;
  assign fwd1_value = '0;
  assign fwd2_value = '0;

  always_comb begin
    w_unused = ^{rs1, rs2, w_mask, w_head_ptr};
    for (int i = 0; i < DEPTH; i++) w_unused = w_unused ^ (^w_entries[i]);
  end
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed self-checking bench for reg_writeback_queue (DEPTH=4, XLEN=32, AW=5).
module tb_reg_writeback_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        rf_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_value;
  logic [31:0] fwd2_value;
  logic [2:0]  pending;

  int n_cmp = 0;
  int n_bad = 0;

  reg_writeback_queue dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_data    (in_data),
    .rf_ready   (rf_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rs1        (rs1),
    .rs2        (rs2),
    .fwd1_hit   (fwd1_hit),
    .fwd2_hit   (fwd2_hit),
    .fwd1_value (fwd1_value),
    .fwd2_value (fwd2_value),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    in_valid = 1'b1;
    in_rd    = rd;
    in_data  = data;
    step();
    in_valid = 1'b0;
  endtask

  logic [4:0]  exp_rd  [4];
  logic [31:0] exp_dat [4];
  logic        exp_hit;
  logic [31:0] exp_val;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_rd    = '0;
    in_data  = '0;
    rf_ready = 1'b0;
    rs1      = '0;
    rs2      = '0;

    // Reset state
    #12;
    check("rst_pending",  pending,    3'd0);
    check("rst_rf_we",    rf_we,      1'b0);
    check("rst_waddr",    rf_waddr,   5'd0);
    check("rst_wdata",    rf_wdata,   32'd0);
    check("rst_in_ready", in_ready,   1'b1);
    check("rst_fwd1_hit", fwd1_hit,   1'b0);
    check("rst_fwd1_val", fwd1_value, 32'd0);
    check("rst_fwd2_hit", fwd2_hit,   1'b0);
    reset = 1'b0;
    step();

    // Single result: visible the cycle after acceptance, written at the next edge
    rf_ready = 1'b1;
    push(5'd1, 32'h11);
    check("t1_rf_we",    rf_we,    1'b1);
    check("t1_waddr",    rf_waddr, 5'd1);
    check("t1_wdata",    rf_wdata, 32'h11);
    check("t1_pending",  pending,  3'd1);
    step();
    check("t1_pend_end", pending,  3'd0);
    check("t1_we_end",   rf_we,    1'b0);

    // x0 result is accepted and dropped
    in_valid = 1'b1;
    in_rd    = 5'd0;
    in_data  = 32'hdead;
    #1;
    check("x0_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("x0_pending",  pending,  3'd0);
    check("x0_rf_we",    rf_we,    1'b0);
    step();
    check("x0_rf_we2",   rf_we,    1'b0);

    // Fill while the register file is busy, reject a fifth push, drain in order
    rf_ready = 1'b0;
    exp_rd  = '{5'd1, 5'd2, 5'd3, 5'd31};
    exp_dat = '{32'h11, 32'h22, 32'h33, 32'hff};
    for (int i = 0; i < 4; i++) push(exp_rd[i], exp_dat[i]);
    check("full_pending",  pending,  3'd4);
    check("full_in_ready", in_ready, 1'b0);
    push(5'd5, 32'h55);
    check("full_reject",   pending,  3'd4);
    check("hold_waddr",    rf_waddr, 5'd1);
    check("hold_wdata",    rf_wdata, 32'h11);
    rf_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_we",    rf_we,    1'b1);
      check("drain_waddr", rf_waddr, exp_rd[i]);
      check("drain_wdata", rf_wdata, exp_dat[i]);
      step();
    end
    check("drain_empty", pending, 3'd0);

    // Forwarding picks the youngest queued write; the entry being pushed is not yet visible
`ifdef WB_BYPASS_EN
    exp_hit = 1'b1;
`else
    exp_hit = 1'b0;
`endif
    rf_ready = 1'b0;
    rs1 = 5'd3;
    rs2 = 5'd0;
    push(5'd3, 32'h33);
    in_valid = 1'b1;
    in_rd    = 5'd3;
    in_data  = 32'h44;
    #1;
    exp_val = exp_hit ? 32'h33 : 32'h0;
    check("fwd_inflight_val", fwd1_value, exp_val);
    step();
    in_valid = 1'b0;
    exp_val = exp_hit ? 32'h44 : 32'h0;
    check("fwd1_hit",   fwd1_hit,   exp_hit);
    check("fwd1_value", fwd1_value, exp_val);
    check("fwd2_hit",   fwd2_hit,   1'b0);
    check("fwd2_value", fwd2_value, 32'h0);
    rs1 = 5'd7;
    #1;
    check("fwd_miss_hit", fwd1_hit,   1'b0);
    check("fwd_miss_val", fwd1_value, 32'h0);
    rs1 = 5'd0;
    rf_ready = 1'b1;
    #1;
    check("same_rd_first", rf_wdata, 32'h33);
    step();
    check("same_rd_second", rf_wdata, 32'h44);
    step();
    check("same_rd_empty", pending, 3'd0);

    // Full queue with a pop at the same edge: push refused, then push+pop holds count
    rf_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(5'(4 + i), 32'h40 + 32'(i));
    rf_ready = 1'b1;
    in_valid = 1'b1;
    in_rd    = 5'd8;
    in_data  = 32'h80;
    #1;
    check("fp_in_ready_lo", in_ready, 1'b0);
    step();
    check("fp_pending3",    pending,  3'd3);
    check("fp_in_ready_hi", in_ready, 1'b1);
    in_rd   = 5'd9;
    in_data = 32'h90;
    step();
    in_valid = 1'b0;
    check("fp_keep3",  pending,  3'd3);
    exp_rd  = '{5'd6, 5'd7, 5'd9, 5'd0};
    exp_dat = '{32'h42, 32'h43, 32'h90, 32'h0};
    for (int i = 0; i < 3; i++) begin
      check("fp_order_addr", rf_waddr, exp_rd[i]);
      check("fp_order_data", rf_wdata, exp_dat[i]);
      step();
    end
    check("fp_empty", pending, 3'd0);

    // Asynchronous reset with entries queued
    rf_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(5'(10 + i), 32'ha0 + 32'(i));
    check("ar_pending_pre", pending, 3'd3);
    #2;
    reset = 1'b1;
    #1;
    check("ar_pending",  pending,  3'd0);
    check("ar_rf_we",    rf_we,    1'b0);
    check("ar_in_ready", in_ready, 1'b1);
    check("ar_waddr",    rf_waddr, 5'd0);
    #3;
    reset = 1'b0;
    step();
    check("ar_stays_empty", pending, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
